// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - runtime-programmable 50%-duty integer clock divider with period strobe
module prog_clock_divider #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_clk,
  output logic             div_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic [DIV_W-1:0] phase
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_PHASE = DIV_W'(DEFAULT_DIV - 1);

  // A reset divisor outside 1..2^DIV_W-1 cannot be represented, so refuse to elaborate.
  if (DEFAULT_DIV < 1 || DEFAULT_DIV > (2 ** DIV_W) - 1) begin : g_bad_default_div
    $error("prog_clock_divider: DEFAULT_DIV out of range 1..2^DIV_W-1");
  end

  logic             pend_v;
  logic [DIV_W-1:0] pend_d;
  logic             p_q;
  logic             n_q;
  logic             run_q;

  logic             wrap;
  logic             accept;
  logic [DIV_W-1:0] div_in_fix;
  logic [DIV_W-1:0] div_next;
  logic [DIV_W-1:0] half_next;
  logic [DIV_W-1:0] phase_next;

  // Next-phase arithmetic; the half-width uses the divisor that will be in force after this edge
  // so a newly applied divisor shapes p_q from phase 0 of its first period.
  always_comb begin
    wrap       = en && (phase == cur_div - ONE);
    accept     = div_valid && !pend_v;
    div_in_fix = (div_in == '0) ? ONE : div_in;
    div_next   = (wrap && pend_v) ? pend_d : cur_div;
    half_next  = div_next >> 1;
    if (!en) begin
      phase_next = phase;
    end else if (wrap) begin
      phase_next = '0;
    end else begin
      phase_next = phase + ONE;
    end
  end

  // Rising-edge state: phase counter, high-phase flop, strobe, and divisor handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_div  <= RST_DIV;
      phase    <= RST_PHASE;
      pend_v   <= 1'b0;
      pend_d   <= RST_DIV;
      p_q      <= 1'b0;
      div_tick <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      phase    <= phase_next;
      div_tick <= wrap;
      run_q    <= en;
      if (en) begin
        p_q <= (phase_next < half_next);
      end
      if (wrap && pend_v) begin
        cur_div <= pend_d;
        pend_v  <= 1'b0;
      end else if (accept) begin
        pend_d <= div_in_fix;
        pend_v <= 1'b1;
      end
    end
  end

  // Falling-edge copy of p_q stretches the high time by half a cycle for odd divisors.
  always_ff @(negedge clk) begin
    if (!reset) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  // Output clock selection: bypass for divide-by-1, half-cycle stretch for odd divisors.
  always_comb begin
    div_ready = !pend_v;
    if (cur_div == ONE) begin
      div_clk = clk & run_q;
    end else if (cur_div[0]) begin
      div_clk = p_q | n_q;
    end else begin
      div_clk = p_q;
    end
  end

endmodule
